// File: rtl/alu_seq_if.sv
// Request/response bundle between the system controller and alu_seq.
// Signal names follow the controller-side register map.
interface alu_seq_if #(
  parameter int OPW  = 8,
  parameter int RESW = 2*OPW
);
  logic [OPW-1:0]  A;
  logic [OPW-1:0]  B;
  logic [3:0]      ALU_FUN;
  logic            Enable;
  logic [RESW-1:0] ALU_OUT;
  logic            OUT_VALID;
  logic            BUSY;
  logic            DIV_ZERO;

  modport master (output A, B, ALU_FUN, Enable,
                  input  ALU_OUT, OUT_VALID, BUSY, DIV_ZERO);
  modport slave  (input  A, B, ALU_FUN, Enable,
                  output ALU_OUT, OUT_VALID, BUSY, DIV_ZERO);
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/compare/shift, iterative MUL/DIV/MOD
// taking OPW cycles, with BUSY handshake and divide-by-zero flag.
module alu_seq #(
  parameter int OPW  = 8,
  parameter int RESW = 2*OPW
) (
  input  logic       CLK,
  input  logic       RST,
  alu_seq_if.slave   bus
);
  localparam int CW = $clog2(OPW+1);
  localparam logic [3:0] F_ADD = 4'd0,  F_SUB = 4'd1,  F_MUL = 4'd2,  F_DIV = 4'd3,
                         F_AND = 4'd4,  F_OR  = 4'd5,  F_NAND = 4'd6, F_NOR = 4'd7,
                         F_XOR = 4'd8,  F_XNOR = 4'd9, F_EQ  = 4'd10, F_GT  = 4'd11,
                         F_LT  = 4'd12, F_SHR = 4'd13, F_SHL = 4'd14, F_MOD = 4'd15;

  typedef enum logic {IDLE, CALC} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [3:0]      op_q;
  logic [RESW-1:0] opa_q;   // MUL: shifting multiplicand; DIV/MOD: dividend -> quotient
  logic [OPW-1:0]  opb_q;   // MUL: shifting multiplier;   DIV/MOD: divisor
  logic [RESW-1:0] acc_q;   // MUL: product;               DIV/MOD: partial remainder
  logic [RESW-1:0] alu_out_q;
  logic            out_valid_q, busy_q, div_zero_q;

  logic [RESW-1:0] ae, be, sc_res, mul_acc_nx;
  logic [OPW:0]    rem_sh, rem_nx;
  logic [OPW-1:0]  quo_nx;
  logic            ge, last;

  always_comb begin
    ae = {{OPW{1'b0}}, bus.A};
    be = {{OPW{1'b0}}, bus.B};
    sc_res = '0;
    case (bus.ALU_FUN)
      F_ADD:  sc_res = ae + be;
      F_SUB:  sc_res = ae - be;
      F_AND:  sc_res = {{OPW{1'b0}}, bus.A & bus.B};
      F_OR:   sc_res = {{OPW{1'b0}}, bus.A | bus.B};
      F_NAND: sc_res = {{OPW{1'b0}}, ~(bus.A & bus.B)};
      F_NOR:  sc_res = {{OPW{1'b0}}, ~(bus.A | bus.B)};
      F_XOR:  sc_res = {{OPW{1'b0}}, bus.A ^ bus.B};
      F_XNOR: sc_res = {{OPW{1'b0}}, ~(bus.A ^ bus.B)};
      F_EQ:   sc_res = (bus.A == bus.B) ? RESW'(1) : '0;
      F_GT:   sc_res = (bus.A >  bus.B) ? RESW'(2) : '0;
      F_LT:   sc_res = (bus.A <  bus.B) ? RESW'(3) : '0;
      F_SHR:  sc_res = ae >> 1;
      F_SHL:  sc_res = ae << 1;
      default: sc_res = '0;
    endcase

    mul_acc_nx = acc_q + (opb_q[0] ? opa_q : '0);
    // Restoring division step: shift next dividend bit into the remainder.
    rem_sh = {acc_q[OPW-1:0], opa_q[OPW-1]};
    ge     = rem_sh >= {1'b0, opb_q};
    rem_nx = ge ? rem_sh - {1'b0, opb_q} : rem_sh;
    quo_nx = {opa_q[OPW-2:0], ge};
    last   = (cnt_q == CW'(OPW-1));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      acc_q       <= '0;
      alu_out_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.Enable) begin
          if (bus.ALU_FUN == F_MUL ||
              ((bus.ALU_FUN == F_DIV || bus.ALU_FUN == F_MOD) && bus.B != '0)) begin
            op_q    <= bus.ALU_FUN;
            opa_q   <= ae;
            opb_q   <= bus.B;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end else if (bus.ALU_FUN == F_DIV || bus.ALU_FUN == F_MOD) begin
            alu_out_q   <= (bus.ALU_FUN == F_DIV) ? '1 : ae;
            out_valid_q <= 1'b1;
            div_zero_q  <= 1'b1;
          end else begin
            alu_out_q   <= sc_res;
            out_valid_q <= 1'b1;
            div_zero_q  <= 1'b0;
          end
        end
        CALC: begin
          cnt_q <= cnt_q + CW'(1);
          if (op_q == F_MUL) begin
            acc_q <= mul_acc_nx;
            opa_q <= opa_q << 1;
            opb_q <= opb_q >> 1;
          end else begin
            acc_q <= {{(RESW-OPW-1){1'b0}}, rem_nx};
            opa_q <= {{OPW{1'b0}}, quo_nx};
          end
          if (last) begin
            alu_out_q   <= (op_q == F_MUL) ? mul_acc_nx :
                           (op_q == F_DIV) ? {{OPW{1'b0}}, quo_nx} :
                                             {{(RESW-OPW-1){1'b0}}, rem_nx};
            out_valid_q <= 1'b1;
            div_zero_q  <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ALU_OUT   = alu_out_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.BUSY      = busy_q;
  assign bus.DIV_ZERO  = div_zero_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed + randomized bench for alu_seq (OPW=8) against an arithmetic reference model.
module tb_alu_seq;
  localparam int OPW = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  alu_seq_if #(.OPW(OPW)) bus ();
  alu_seq #(.OPW(OPW)) dut (.CLK(clk), .RST(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    int ai, bi, r;
    ai = a; bi = b; r = 0;
    case (f)
      0:  r = ai + bi;
      1:  r = ai - bi;
      2:  r = ai * bi;
      3:  r = (bi == 0) ? 'hFFFF : ai / bi;
      4:  r = a & b;
      5:  r = a | b;
      6:  r = ~(a & b) & 'hFF;
      7:  r = ~(a | b) & 'hFF;
      8:  r = a ^ b;
      9:  r = ~(a ^ b) & 'hFF;
      10: r = (ai == bi) ? 1 : 0;
      11: r = (ai > bi) ? 2 : 0;
      12: r = (ai < bi) ? 3 : 0;
      13: r = ai / 2;
      14: r = ai * 2;
      default: r = (bi == 0) ? ai : ai % bi;
    endcase
    return r[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue one op for a single cycle, then scramble inputs to show captured copies are used.
  task automatic do_op(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] exp;
    bit dz, multi;
    int lat;
    exp   = model(f, a, b);
    dz    = (f == 3 || f == 15) && b == 0;
    multi = (f == 2 || f == 3 || f == 15) && b != 0;
    bus.A = a; bus.B = b; bus.ALU_FUN = f; bus.Enable = 1'b1;
    tick();
    bus.Enable = 1'b0;
    bus.A = 8'($urandom); bus.B = 8'($urandom); bus.ALU_FUN = 4'($urandom);
    if (multi) begin
      chk("busy_set", bus.BUSY, 1);
      chk("no_early_valid", bus.OUT_VALID, 0);
      lat = 0;
      while (!bus.OUT_VALID && lat < 40) begin tick(); lat++; end
      chk("latency", lat, OPW);
    end
    chk($sformatf("result f=%0d a=%0h b=%0h", f, a, b), bus.ALU_OUT, exp);
    chk("valid", bus.OUT_VALID, 1);
    chk("div_zero", bus.DIV_ZERO, dz);
    chk("busy_clr", bus.BUSY, 0);
    tick();
    chk("valid_pulse", bus.OUT_VALID, 0);
    chk("hold", bus.ALU_OUT, exp);
  endtask

  initial begin
    int lat, pulses;
    logic [3:0] f;
    logic [7:0] a, b;
    bus.A = '0; bus.B = '0; bus.ALU_FUN = '0; bus.Enable = 1'b0;
    #2;
    chk("rst_out",   bus.ALU_OUT, 0);
    chk("rst_valid", bus.OUT_VALID, 0);
    chk("rst_busy",  bus.BUSY, 0);
    chk("rst_dz",    bus.DIV_ZERO, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    do_op(0, 8'hFF, 8'h01);
    do_op(1, 8'h01, 8'h02);
    do_op(2, 8'd200, 8'd100);
    do_op(2, 8'hFF, 8'hFF);
    do_op(3, 8'd200, 8'd7);
    do_op(15, 8'd200, 8'd7);
    do_op(3, 8'h55, 8'h00);
    do_op(15, 8'h55, 8'h00);
    do_op(11, 8'h10, 8'h0F);
    do_op(12, 8'h0F, 8'h10);
    do_op(14, 8'hFF, 8'h00);

    // Back-to-back single-cycle accepts.
    bus.A = 8'h0F; bus.B = 8'hF0; bus.ALU_FUN = 4'd5; bus.Enable = 1'b1;
    tick();
    chk("b2b_or", bus.ALU_OUT, 16'h00FF);
    chk("b2b_or_v", bus.OUT_VALID, 1);
    bus.ALU_FUN = 4'd9;
    tick();
    chk("b2b_xnor", bus.ALU_OUT, 16'h0000);
    chk("b2b_xnor_v", bus.OUT_VALID, 1);
    bus.Enable = 1'b0;
    tick();
    chk("b2b_end", bus.OUT_VALID, 0);

    // Enable held with ADD during MUL must be ignored.
    bus.A = 8'd200; bus.B = 8'd100; bus.ALU_FUN = 4'd2; bus.Enable = 1'b1;
    tick();
    bus.A = 8'd1; bus.B = 8'd1; bus.ALU_FUN = 4'd0;
    lat = 0;
    while (!bus.OUT_VALID && lat < 40) begin tick(); lat++; end
    bus.Enable = 1'b0;
    chk("hold_en_lat", lat, OPW);
    chk("hold_en_mul", bus.ALU_OUT, 16'd20000);
    tick();
    chk("hold_en_nopulse", bus.OUT_VALID, 0);
    chk("hold_en_keep", bus.ALU_OUT, 16'd20000);
    do_op(0, 8'd1, 8'd1);

    // Async reset four cycles into a MUL.
    bus.A = 8'd123; bus.B = 8'd45; bus.ALU_FUN = 4'd2; bus.Enable = 1'b1;
    tick();
    bus.Enable = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_out",   bus.ALU_OUT, 0);
    chk("arst_valid", bus.OUT_VALID, 0);
    chk("arst_busy",  bus.BUSY, 0);
    chk("arst_dz",    bus.DIV_ZERO, 0);
    tick();
    rst = 1'b0;
    pulses = 0;
    repeat (12) begin tick(); if (bus.OUT_VALID) pulses++; end
    chk("no_stale_valid", pulses, 0);
    do_op(10, 8'h3C, 8'h3C);

    // Randomized ops, occasionally with zero divisor.
    for (int i = 0; i < 60; i++) begin
      f = 4'($urandom_range(0, 15));
      a = 8'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      do_op(f, a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised sequential ALU, successor to the single-cycle 8-bit ALU in the control datapath. Operand width is generic (`OPW`) and the result is 2·`OPW` bits wide. Logic, add, sub, compare and shift complete in one cycle. Multiply, divide and modulo run as iterative multi-cycle operations with a `BUSY` handshake and a divide-by-zero flag. It sits between the register file and the UART TX framing logic, driven by the system controller.

Parameters:
- `OPW`, 8, operand width in bits (≥2).
- `RESW`, 2*`OPW`, result width; fixed relation, not overridden independently.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `A`  in  `OPW`  operand A, unsigned.
- `B`  in  `OPW`  operand B, unsigned.
- `ALU_FUN`  in  4  operation select.
- `Enable`  in  1  request; accepted when `BUSY`=0.
- `ALU_OUT`  out  `RESW`  result, registered.
- `OUT_VALID`  out  1  one-cycle pulse, `ALU_OUT` new this cycle.
- `BUSY`  out  1  multi-cycle op in progress.
- `DIV_ZERO`  out  1  qualifies `OUT_VALID`; last DIV/MOD had `B`=0.

Behaviour:
- Reset (async, `RST`=1): `ALU_OUT`=0, `OUT_VALID`=0, `BUSY`=0, `DIV_ZERO`=0. FSM goes to IDLE, iteration counter=0, internal operand/accumulator registers=0. Reset mid-operation aborts it; no `OUT_VALID` is emitted.
- Accept: rising edge with `Enable`=1 and `BUSY`=0. `A`, `B` and `ALU_FUN` are captured. `Enable` while `BUSY`=1 is ignored (no queueing).
- `ALU_FUN` encoding (single-cycle unless noted):
  - 0 ADD: zero-extended sum; carry lands in bit `OPW`.
  - 1 SUB: (A−B) mod 2^`RESW`; A<B yields upper-ones two's complement.
  - 2 MUL: A*B, multi-cycle.
  - 3 DIV: A/B quotient, multi-cycle.
  - 4 AND, 5 OR, 6 NAND, 7 NOR, 8 XOR, 9 XNOR: bitwise on `OPW` bits, zero-extended.
  - 10 EQ: 1 if A==B else 0.
  - 11 GT: 2 if A>B else 0.
  - 12 LT: 3 if A<B else 0.
  - 13 SHR: A>>1.
  - 14 SHL: A<<1 (`OPW`+1 significant bits).
  - 15 MOD: A%B, multi-cycle.
- Single-cycle timing: result in `ALU_OUT` and `OUT_VALID`=1 after the accept edge k; `OUT_VALID` clears after edge k+1 unless a new accept occurs. Back-to-back accepts every cycle are legal.
- Multi-cycle FSM, IDLE → CALC → IDLE:
  - Accept at edge k loads operands, sets `BUSY`=1 and counter=0.
  - CALC performs one iteration per edge, k+1 … k+`OPW`: shift-add for MUL, restoring shift-subtract for DIV/MOD.
  - At edge k+`OPW` the result is registered, `OUT_VALID`=1, `BUSY`=0, state returns to IDLE.
  - Latency is `OPW` cycles after accept. The next accept is possible at edge k+`OPW`+1.
- Divide by zero (DIV/MOD with `B`=0): no CALC. At edge k, `OUT_VALID`=1 and `DIV_ZERO`=1. `ALU_OUT` = all-ones for DIV, or zero-extended A for MOD. `BUSY` stays 0.
- `DIV_ZERO` is updated only on `OUT_VALID` cycles; it is 0 for every other result.
- `ALU_OUT` holds its last value between results; it is never cleared except by reset.
- `A`/`B`/`ALU_FUN` changes during `BUSY` have no effect (captured copies are used).
- No combinational path from inputs to outputs.

Test Plan (`OPW`=8):
- ADD A=0xFF, B=0x01, `Enable` 1 cycle → next cycle `ALU_OUT`=0x0100, `OUT_VALID`=1 for exactly 1 cycle, `BUSY`=0. SUB A=0x01, B=0x02 → 0xFFFF.
- MUL A=200, B=100 → `BUSY`=1 for 8 cycles, then `ALU_OUT`=0x4E20 (20000) with a single `OUT_VALID` pulse. MUL 0xFF*0xFF → 0xFE01.
- DIV A=200, B=7 → after 8 cycles `ALU_OUT`=0x001C, `DIV_ZERO`=0. MOD with the same operands → 0x0004.
- DIV A=0x55, B=0 → 1-cycle result `ALU_OUT`=0xFFFF, `DIV_ZERO`=1, `BUSY` never set. MOD A=0x55, B=0 → 0x0055, `DIV_ZERO`=1.
- During MUL, hold `Enable`=1 with ADD A=1, B=1 → ignored; only the MUL result is emitted. Re-issuing ADD after `BUSY` falls → 0x0002 one cycle later.
- Assert `RST` 4 cycles into MUL → all outputs 0 immediately (async). After release, no stale `OUT_VALID`, and an EQ A=B=0x3C yields 0x0001.
